// File: rtl/sys_defs_pkg.sv
// ---------------------------------------------------------------------------
// sys_defs
// Shared bus definitions for the processor-memory interface.
//   BUS_COMMAND    : command issued on a memory port
//   MEM_ARB_SRC    : which requester owns a memory transaction
//   MEM_TAG_OWNER  : one owner-table entry {valid, owner}
//   `MEM_TAG_BITS  : width of a memory tag (tag 0 means "no tag / rejected")
// ---------------------------------------------------------------------------
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } MEM_ARB_SRC;

  typedef struct packed {
    logic       valid;
    MEM_ARB_SRC owner;
  } MEM_TAG_OWNER;

  localparam int MEM_TAG_W = `MEM_TAG_BITS;

endpackage

// File: rtl/mem_bus_arbiter_owner_table.sv
// ---------------------------------------------------------------------------
// mem_tag_owner_table
// Remembers which requester owns each outstanding load tag, looks up the
// owner of a returning tag, frees the entry on return, and flags returns
// that arrive on a tag nobody owns.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   i_allocEn      : record a new accepted load this cycle
//   i_allocTag     : tag handed out by memory for that load
//   i_allocOwner   : requester that was granted the load
//   i_retTag       : tag currently returning from memory (0 = none)
//   o_retHit       : the returning tag has a valid owner
//   o_retOwner     : owner of the returning tag (meaningful with o_retHit)
//   o_strayErr     : sticky, a return arrived on an unowned tag
// ---------------------------------------------------------------------------
module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_allocEn,
  input  logic [`MEM_TAG_BITS-1:0] i_allocTag,
  input  MEM_ARB_SRC               i_allocOwner,
  input  logic [`MEM_TAG_BITS-1:0] i_retTag,
  output logic                     o_retHit,
  output MEM_ARB_SRC               o_retOwner,
  output logic                     o_strayErr
);

  MEM_TAG_OWNER r_table [NUM_TAGS];
  logic         r_strayErr;
  logic         w_retPresent;
  MEM_TAG_OWNER w_retEntry;

  // Lookup of the returning tag against the current (pre-edge) table so a
  // tag that is returned and re-allocated in the same cycle is still routed
  // to its old owner.
  always_comb begin
    w_retPresent = (i_retTag != '0);
    w_retEntry   = r_table[i_retTag];
    o_retHit     = w_retPresent && w_retEntry.valid;
    o_retOwner   = w_retEntry.owner;
  end

  // Free on return, then allocate; the allocation is written last so it
  // wins when both target the same entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_table[i] <= '{valid: 1'b0, owner: SRC_ICACHE};
      end
      r_strayErr <= 1'b0;
    end else begin
      if (w_retPresent && w_retEntry.valid) begin
        r_table[i_retTag].valid <= 1'b0;
      end
      if (w_retPresent && !w_retEntry.valid) begin
        r_strayErr <= 1'b1;
      end
      if (i_allocEn) begin
        r_table[i_allocTag] <= '{valid: 1'b1, owner: i_allocOwner};
      end
    end
  end

  assign o_strayErr = r_strayErr;

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single processor-memory port between the I-cache fetch path and
// the D-cache controller. One request is granted per cycle, combinationally.
// The D-cache has priority, but after STARVE_LIMIT consecutive denied I-cache
// cycles the I-cache is forced to win one cycle. Load tags are remembered so
// returning data is routed only to the requester that issued the load.
// Ports:
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   proc2Imem_* / Imem2proc_* : I-cache request and response/return
//   proc2Dmem_* / Dmem2proc_* : D-cache request and response/return
//   proc2mem_*             : command/address/data to memory
//   mem2proc_*             : memory accept tag, return data and return tag
//   stray_tag_err          : sticky, a return arrived on an unowned tag
// Optional feature macro MEM_ARB_STATS_EN adds i_grant_cnt, d_grant_cnt and
// i_starve_cnt statistics outputs (width STAT_W, wrapping).
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int STAT_W       = 32
`endif
) (
  input  logic                     clock,
  input  logic                     reset,
  input  BUS_COMMAND               proc2Imem_command,
  input  logic [63:0]              proc2Imem_addr,
  output logic [`MEM_TAG_BITS-1:0] Imem2proc_response,
  output logic [63:0]              Imem2proc_data,
  output logic [`MEM_TAG_BITS-1:0] Imem2proc_tag,
  input  BUS_COMMAND               proc2Dmem_command,
  input  logic [63:0]              proc2Dmem_addr,
  input  logic [63:0]              proc2Dmem_data,
  output logic [`MEM_TAG_BITS-1:0] Dmem2proc_response,
  output logic [63:0]              Dmem2proc_data,
  output logic [`MEM_TAG_BITS-1:0] Dmem2proc_tag,
  output BUS_COMMAND               proc2mem_command,
  output logic [63:0]              proc2mem_addr,
  output logic [63:0]              proc2mem_data,
  input  logic [`MEM_TAG_BITS-1:0] mem2proc_response,
  input  logic [63:0]              mem2proc_data,
  input  logic [`MEM_TAG_BITS-1:0] mem2proc_tag,
  output logic                     stray_tag_err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]        i_grant_cnt,
  output logic [STAT_W-1:0]        d_grant_cnt,
  output logic [STAT_W-1:0]        i_starve_cnt
`endif
);

  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starveCnt;
  logic             w_iReq;
  logic             w_dReq;
  logic             w_forceI;
  logic             w_grantI;
  logic             w_grantD;
  logic             w_accepted;
  logic             w_allocEn;
  MEM_ARB_SRC       w_allocOwner;
  logic             w_retHit;
  MEM_ARB_SRC       w_retOwner;
  logic             w_strayErr;

  // Grant decision. Nothing is granted while reset is held so every output
  // reads idle during reset.
  always_comb begin
    w_iReq     = (proc2Imem_command != BUS_NONE);
    w_dReq     = (proc2Dmem_command != BUS_NONE);
    w_forceI   = w_iReq && (r_starveCnt == STARVE_MAX);
    w_grantI   = !reset && w_iReq && (w_forceI || !w_dReq);
    w_grantD   = !reset && w_dReq && !w_grantI;
    w_accepted = (mem2proc_response != '0);
  end

  // Memory-side mux and per-requester accept responses; also decides
  // whether this cycle's transaction needs an owner-table entry.
  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Imem2proc_response = '0;
    Dmem2proc_response = '0;
    w_allocOwner       = SRC_ICACHE;
    if (w_grantI) begin
      proc2mem_command   = proc2Imem_command;
      proc2mem_addr      = proc2Imem_addr;
      Imem2proc_response = mem2proc_response;
      w_allocOwner       = SRC_ICACHE;
    end else if (w_grantD) begin
      proc2mem_command   = proc2Dmem_command;
      proc2mem_addr      = proc2Dmem_addr;
      proc2mem_data      = proc2Dmem_data;
      Dmem2proc_response = mem2proc_response;
      w_allocOwner       = SRC_DCACHE;
    end
    w_allocEn = (w_grantI || w_grantD) && w_accepted && (proc2mem_command == BUS_LOAD);
  end

  // Return path: data is broadcast, the tag is shown only to the owner.
  always_comb begin
    Imem2proc_tag  = '0;
    Dmem2proc_tag  = '0;
    Imem2proc_data = reset ? '0 : mem2proc_data;
    Dmem2proc_data = reset ? '0 : mem2proc_data;
    if (!reset && w_retHit) begin
      if (w_retOwner == SRC_ICACHE) begin
        Imem2proc_tag = mem2proc_tag;
      end else begin
        Dmem2proc_tag = mem2proc_tag;
      end
    end
  end

  // Starvation counter: counts denied I-cache cycles up to the limit, clears
  // on an accepted I-cache grant or an idle I-cache, and holds when an
  // I-cache grant is rejected by memory so a forced grant is retried.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starveCnt <= '0;
    end else if (w_iReq && !w_grantI) begin
      if (r_starveCnt != STARVE_MAX) begin
        r_starveCnt <= r_starveCnt + CNT_W'(1);
      end
    end else if (!w_iReq || w_accepted) begin
      r_starveCnt <= '0;
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_ownerTable (
    .clock        (clock),
    .reset        (reset),
    .i_allocEn    (w_allocEn),
    .i_allocTag   (mem2proc_response),
    .i_allocOwner (w_allocOwner),
    .i_retTag     (mem2proc_tag),
    .o_retHit     (w_retHit),
    .o_retOwner   (w_retOwner),
    .o_strayErr   (w_strayErr)
  );

  assign stray_tag_err = w_strayErr;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_iGrantCnt;
  logic [STAT_W-1:0] r_dGrantCnt;
  logic [STAT_W-1:0] r_iStarveCnt;

  // Statistics: accepted grants per requester, and grants where the
  // I-cache overrode a pending D-cache request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iGrantCnt  <= '0;
      r_dGrantCnt  <= '0;
      r_iStarveCnt <= '0;
    end else begin
      if (w_grantI && w_accepted) begin
        r_iGrantCnt <= r_iGrantCnt + STAT_W'(1);
      end
      if (w_grantD && w_accepted) begin
        r_dGrantCnt <= r_dGrantCnt + STAT_W'(1);
      end
      if (w_grantI && w_forceI && w_dReq) begin
        r_iStarveCnt <= r_iStarveCnt + STAT_W'(1);
      end
    end
  end

  assign i_grant_cnt  = r_iGrantCnt;
  assign d_grant_cnt  = r_dGrantCnt;
  assign i_starve_cnt = r_iStarveCnt;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural
// model of the arbitration, starvation and tag-ownership rules.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import sys_defs::*;

  localparam int STARVE_LIMIT = 4;
  localparam int NUM_TAGS     = 16;

  logic        clock;
  logic        reset;
  BUS_COMMAND  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  BUS_COMMAND  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;
  BUS_COMMAND  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        stray_tag_err;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] i_grant_cnt;
  logic [31:0] d_grant_cnt;
  logic [31:0] i_starve_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: starvation count, per-tag ownership and the sticky error.
  int mStarve;
  bit mValid  [NUM_TAGS];
  bit mOwnerD [NUM_TAGS];
  bit mStray;
  int mIGrants;
  int mDGrants;
  int mForced;

  mem_bus_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .NUM_TAGS     (NUM_TAGS)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_data     (Dmem2proc_data),
    .Dmem2proc_tag      (Dmem2proc_tag),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .stray_tag_err      (stray_tag_err)
`ifdef MEM_ARB_STATS_EN
    ,
    .i_grant_cnt        (i_grant_cnt),
    .d_grant_cnt        (d_grant_cnt),
    .i_starve_cnt       (i_starve_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearModel();
    mStarve  = 0;
    mStray   = 1'b0;
    mIGrants = 0;
    mDGrants = 0;
    mForced  = 0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      mValid[i]  = 1'b0;
      mOwnerD[i] = 1'b0;
    end
  endtask

  task automatic driveIdle();
    proc2Imem_command = BUS_NONE;
    proc2Imem_addr    = '0;
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    mem2proc_response = '0;
    mem2proc_data     = '0;
    mem2proc_tag      = '0;
  endtask

  // One bus cycle: drive after the falling edge, compare combinational
  // outputs against the model, then advance the model to the next edge.
  task automatic applyStimulus(input BUS_COMMAND iCmd, input logic [63:0] iAddr,
                               input BUS_COMMAND dCmd, input logic [63:0] dAddr,
                               input logic [63:0] dData, input logic [3:0] resp,
                               input logic [3:0] rTag, input logic [63:0] rData,
                               output bit iAccepted);
    int          winner;
    bit          iReq;
    bit          dReq;
    logic [3:0]  effResp;
    BUS_COMMAND  expCmd;
    logic [63:0] expAddr;
    logic [63:0] expData;
    logic [3:0]  expITag;
    logic [3:0]  expDTag;
    iReq = (iCmd != BUS_NONE);
    dReq = (dCmd != BUS_NONE);
    if (iReq && mStarve == STARVE_LIMIT) winner = 1;
    else if (dReq)                       winner = 2;
    else if (iReq)                       winner = 1;
    else                                 winner = 0;
    effResp = (winner == 0) ? 4'd0 : resp;
    expCmd  = (winner == 1) ? iCmd  : (winner == 2) ? dCmd  : BUS_NONE;
    expAddr = (winner == 1) ? iAddr : (winner == 2) ? dAddr : 64'd0;
    expData = (winner == 2) ? dData : 64'd0;
    expITag = 4'd0;
    expDTag = 4'd0;
    if (rTag != 4'd0 && mValid[rTag]) begin
      if (mOwnerD[rTag]) expDTag = rTag;
      else               expITag = rTag;
    end

    @(negedge clock);
    proc2Imem_command = iCmd;
    proc2Imem_addr    = iAddr;
    proc2Dmem_command = dCmd;
    proc2Dmem_addr    = dAddr;
    proc2Dmem_data    = dData;
    mem2proc_response = effResp;
    mem2proc_tag      = rTag;
    mem2proc_data     = rData;
    #1;
    checkOutput("memCmd",  64'(proc2mem_command),   64'(expCmd));
    checkOutput("memAddr", proc2mem_addr,           expAddr);
    checkOutput("memData", proc2mem_data,           expData);
    checkOutput("iResp",   64'(Imem2proc_response), 64'((winner == 1) ? effResp : 4'd0));
    checkOutput("dResp",   64'(Dmem2proc_response), 64'((winner == 2) ? effResp : 4'd0));
    checkOutput("iTag",    64'(Imem2proc_tag),      64'(expITag));
    checkOutput("dTag",    64'(Dmem2proc_tag),      64'(expDTag));
    checkOutput("iData",   Imem2proc_data,          rData);
    checkOutput("dData",   Dmem2proc_data,          rData);
    checkOutput("stray",   64'(stray_tag_err),      64'(mStray));
`ifdef MEM_ARB_STATS_EN
    checkOutput("iGrantCnt",  64'(i_grant_cnt),  64'(mIGrants));
    checkOutput("dGrantCnt",  64'(d_grant_cnt),  64'(mDGrants));
    checkOutput("iStarveCnt", 64'(i_starve_cnt), 64'(mForced));
`endif

    iAccepted = (winner == 1) && (effResp != 4'd0);
    if (winner == 1 && effResp != 4'd0) mIGrants++;
    if (winner == 2 && effResp != 4'd0) mDGrants++;
    if (winner == 1 && dReq && mStarve == STARVE_LIMIT) mForced++;
    if (iReq && winner != 1) mStarve = (mStarve < STARVE_LIMIT) ? mStarve + 1 : STARVE_LIMIT;
    else if (iAccepted || !iReq) mStarve = 0;
    if (rTag != 4'd0) begin
      if (mValid[rTag]) mValid[rTag] = 1'b0;
      else              mStray = 1'b1;
    end
    if (winner != 0 && effResp != 4'd0 && expCmd == BUS_LOAD) begin
      mValid[effResp]  = 1'b1;
      mOwnerD[effResp] = (winner == 2);
    end
  endtask

  // Asynchronous reset in the middle of a cycle with live requests and a
  // live return on the bus; outputs must go idle without a clock edge.
  task automatic doReset();
    @(negedge clock);
    proc2Imem_command = BUS_LOAD;
    proc2Imem_addr    = 64'h0BAD;
    proc2Dmem_command = BUS_LOAD;
    proc2Dmem_addr    = 64'h0BEE;
    mem2proc_response = 4'd5;
    mem2proc_tag      = 4'd2;
    mem2proc_data     = 64'h77;
    #2 reset = 1'b1;
    #1;
    checkOutput("rstMemCmd", 64'(proc2mem_command),   64'(BUS_NONE));
    checkOutput("rstIResp",  64'(Imem2proc_response), 64'd0);
    checkOutput("rstDResp",  64'(Dmem2proc_response), 64'd0);
    checkOutput("rstITag",   64'(Imem2proc_tag),      64'd0);
    checkOutput("rstDTag",   64'(Dmem2proc_tag),      64'd0);
    checkOutput("rstStray",  64'(stray_tag_err),      64'd0);
    clearModel();
    @(negedge clock);
    driveIdle();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bit         acc;
    bit         iPending;
    logic [63:0] iAddrHeld;
    BUS_COMMAND dCmd;
    int         r;
    logic [3:0] resp;
    logic [3:0] rTag;

    reset = 1'b1;
    driveIdle();
    clearModel();
    #3;
    checkOutput("initMemCmd", 64'(proc2mem_command), 64'(BUS_NONE));
    checkOutput("initStray",  64'(stray_tag_err),    64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // D and I collide; D wins with tag 3, which then returns to D.
    applyStimulus(BUS_LOAD, 64'h200, BUS_LOAD, 64'h100, 64'h0, 4'd3, 4'd0, 64'h0, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'h1234_5678, acc);

    // I load on tag 5 returns 0xDEAD to the I-cache only.
    applyStimulus(BUS_LOAD, 64'h500, BUS_NONE, 64'h0, 64'h0, 4'd5, 4'd0, 64'h0, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd5, 64'hDEAD, acc);

    // Rejected D load, then accepted retry on tag 7.
    applyStimulus(BUS_NONE, 64'h0, BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 64'h0, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_LOAD, 64'h300, 64'h0, 4'd7, 4'd0, 64'h0, acc);

    // Tag 9 returned to D while being re-allocated to I in the same cycle.
    applyStimulus(BUS_NONE, 64'h0, BUS_LOAD, 64'h80, 64'h0, 4'd9, 4'd0, 64'h0, acc);
    applyStimulus(BUS_LOAD, 64'h90, BUS_NONE, 64'h0, 64'h0, 4'd9, 4'd9, 64'h99, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd9, 64'h98, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd7, 64'h97, acc);

    // Starvation: D every cycle, I held; I is forced through on cycle 5.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(BUS_LOAD, 64'h600, BUS_LOAD, 64'h700 + 64'(k), 64'h0, 4'(k + 1), 4'd0, 64'h0, acc);
    end
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'(k), 64'(k), acc);
    end

    // Store allocates nothing: its tag comes back as stray; tag 5 was freed.
    applyStimulus(BUS_NONE, 64'h0, BUS_STORE, 64'hA0, 64'hCAFE, 4'd7, 4'd0, 64'h0, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd7, 64'h1, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd5, 64'h2, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h3, acc);

    // Reset with tags 2 and 4 outstanding; a later tag-2 return is stray.
    doReset();
    applyStimulus(BUS_LOAD, 64'h220, BUS_NONE, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_LOAD, 64'h440, 64'h0, 4'd4, 4'd0, 64'h0, acc);
    doReset();
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd2, 64'h5, acc);
    applyStimulus(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h6, acc);

    // Randomized traffic: the I-cache holds its request until accepted.
    doReset();
    iPending  = 1'b0;
    iAddrHeld = '0;
    for (int n = 0; n < 600; n++) begin
      if (!iPending && $urandom_range(0, 1) == 1) begin
        iPending  = 1'b1;
        iAddrHeld = {$urandom(), $urandom()};
      end
      r = $urandom_range(0, 9);
      dCmd = (r < 3) ? BUS_NONE : (r < 8) ? BUS_LOAD : BUS_STORE;
      resp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rTag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      applyStimulus(iPending ? BUS_LOAD : BUS_NONE, iAddrHeld, dCmd,
                    {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    resp, rTag, {$urandom(), $urandom()}, acc);
      if (acc) iPending = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
